// File: rtl/amba_apb4_mem_slave_pkg.sv
// Shared types, widths and helpers for the APB4 memory slave and its wait-state generator.
package amba_apb4_mem_slave_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int APB_PROT_W = 3;
  // Wide enough for WAIT_CYCLES (0..15) plus an LFSR offset of up to 7.
  localparam int WAIT_CNT_W = 5;

  function automatic int strb_width(input int data_size);
    return data_size / 8;
  endfunction

  function automatic int word_shift(input int data_size);
    return $clog2(data_size / 8);
  endfunction

endpackage

// File: rtl/amba_apb4_mem_slave_if.sv
// APB4 bus bundle between one master and one memory slave.
interface amba_apb4_mem_slave_if
  import amba_apb4_mem_slave_pkg::*;
#(
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 32
) ();

  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [ADDR_SIZE-1:0]    paddr;
  logic [DATA_SIZE-1:0]    pwdata;
  logic [DATA_SIZE/8-1:0]  pstrb;
  logic [APB_PROT_W-1:0]   pprot;
  logic [DATA_SIZE-1:0]    prdata;
  logic                    pready;
  logic                    pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/amba_apb4_mem_slave_wait_gen.sv
// Wait-state counter for the APB4 memory slave; optional LFSR jitter when APB_SLV_LFSR_WAIT_EN is defined.
module amba_apb4_mem_slave_wait_gen
  import amba_apb4_mem_slave_pkg::*;
#(
  parameter int WAIT_CYCLES = 0
) (
  input  logic pclk,
  input  logic preset,
  input  logic i_start,
  input  logic i_count,
  input  logic i_advance,
  output logic o_done
);

  localparam int CNT_W = WAIT_CNT_W;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_target;

`ifdef APB_SLV_LFSR_WAIT_EN
  logic [15:0] r_lfsr;

  // Fibonacci taps 16,14,13,11; stepped once per completed transfer.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_lfsr <= 16'hACE1;
    end else if (i_advance) begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  assign w_target = CNT_W'(WAIT_CYCLES) + CNT_W'(r_lfsr[2:0]);
`else
  logic w_unused;

  assign w_unused = i_advance;
  assign w_target = CNT_W'(WAIT_CYCLES);
`endif

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= '0;
    end else if (i_count && !o_done) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_done = (r_cnt == w_target);

endmodule

// File: rtl/amba_apb4_mem_slave.sv
// Parametrised APB4 memory slave with byte strobes, range error and per-word written tracking.
// Define APB_SLV_LFSR_WAIT_EN to add pseudo-random extra wait states.
module amba_apb4_mem_slave
  import amba_apb4_mem_slave_pkg::*;
#(
  parameter int                   ADDR_SIZE   = 32,
  parameter int                   DATA_SIZE   = 32,
  parameter int                   MEM_DEPTH   = 256,
  parameter logic [ADDR_SIZE-1:0] BASE_ADDR   = '0,
  parameter int                   WAIT_CYCLES = 0
) (
  input  logic                  pclk,
  input  logic                  preset,
  amba_apb4_mem_slave_if.slave  apb
);

  localparam int                 BYTES = strb_width(DATA_SIZE);
  localparam int                 SHIFT = word_shift(DATA_SIZE);
  localparam int                 IDX_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_SIZE:0] SPAN  = (ADDR_SIZE + 1)'(MEM_DEPTH * BYTES);

  apb_state_e            r_state;
  apb_state_e            w_state_next;
  logic                  w_capture;
  logic                  w_done;
  logic                  w_ready;
  logic                  w_complete;
  logic                  w_commit;
  logic                  w_rd_capture;
  logic                  w_fwd_hit;
  logic                  w_in_setup;
  logic                  w_in_access;

  logic [ADDR_SIZE:0]    w_off;
  logic                  w_in_range;
  logic [IDX_W-1:0]      w_idx;

  logic                  r_write;
  logic                  r_in_range;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_SIZE-1:0]  r_wdata;
  logic [BYTES-1:0]      r_strb;
  logic [APB_PROT_W-1:0] r_prot;

  logic [MEM_DEPTH-1:0]  r_written;
  logic [DATA_SIZE-1:0]  r_mem [MEM_DEPTH];
  logic [DATA_SIZE-1:0]  r_rd_data;
  logic [DATA_SIZE-1:0]  r_fwd_data;
  logic [BYTES-1:0]      r_fwd_strb;
  logic                  r_rd_valid;
  logic [DATA_SIZE-1:0]  w_rd_merge;
  logic                  w_unused;

  // Extra top bit catches paddr < BASE_ADDR as a borrow.
  assign w_off      = {1'b0, apb.paddr} - {1'b0, BASE_ADDR};
  assign w_in_range = !w_off[ADDR_SIZE] && (w_off < SPAN);
  assign w_idx      = w_off[SHIFT +: IDX_W];

  assign w_in_setup  = (r_state == SETUP);
  assign w_in_access = (r_state == ACCESS);

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (apb.psel && !apb.penable) begin
          w_state_next = SETUP;
          w_capture    = 1'b1;
        end
      end
      SETUP: begin
        w_state_next = ACCESS;
      end
      ACCESS: begin
        if (!apb.psel) begin
          w_state_next = IDLE;
        end else if (w_ready) begin
          if (!apb.penable) begin
            w_state_next = SETUP;
            w_capture    = 1'b1;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  amba_apb4_mem_slave_wait_gen #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_gen (
    .pclk      (pclk),
    .preset    (preset),
    .i_start   (w_in_setup),
    .i_count   (w_in_access),
    .i_advance (w_complete),
    .o_done    (w_done)
  );

  assign w_ready      = w_in_access && w_done;
  // A dropped psel wins over pready: the transfer is treated as aborted.
  assign w_complete   = w_ready && apb.psel;
  assign w_commit     = w_complete && r_write && r_in_range;
  assign w_rd_capture = w_capture && !apb.pwrite;
  assign w_fwd_hit    = w_commit && (r_idx == w_idx);

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_state    <= IDLE;
      r_write    <= 1'b0;
      r_in_range <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_strb     <= '0;
      r_prot     <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_capture) begin
        r_write    <= apb.pwrite;
        r_in_range <= w_in_range;
        r_idx      <= w_idx;
        r_wdata    <= apb.pwdata;
        r_strb     <= apb.pstrb;
        r_prot     <= apb.pprot;
      end
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_written  <= '0;
      r_rd_valid <= 1'b0;
      r_fwd_strb <= '0;
    end else begin
      if (w_commit) begin
        r_written[r_idx] <= 1'b1;
      end
      if (w_rd_capture) begin
        r_rd_valid <= w_in_range && (r_written[w_idx] || w_fwd_hit);
        r_fwd_strb <= w_fwd_hit ? r_strb : '0;
      end
    end
  end

  // Array kept free of reset so it maps onto block RAM with a registered read port.
  always_ff @(posedge pclk) begin
    if (w_commit) begin
      for (int b = 0; b < BYTES; b++) begin
        if (r_strb[b]) begin
          r_mem[r_idx][b*8 +: 8] <= r_wdata[b*8 +: 8];
        end
      end
    end
    if (w_rd_capture) begin
      r_rd_data  <= r_mem[w_idx];
      r_fwd_data <= r_wdata;
    end
  end

  // A read set up on the same edge a write commits to that word sees the new bytes.
  generate
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
      assign w_rd_merge[gi*8 +: 8] = r_fwd_strb[gi] ? r_fwd_data[gi*8 +: 8]
                                                     : r_rd_data[gi*8 +: 8];
    end
  endgenerate

  assign apb.prdata  = r_rd_valid ? w_rd_merge : '0;
  assign apb.pready  = w_ready;
  assign apb.pslverr = w_ready && !r_in_range;

  assign w_unused = ^{r_prot, w_off};

endmodule

// File: tb/tb_amba_apb4_mem_slave.sv
// Directed bench for amba_apb4_mem_slave: a master task queues expected responses, a monitor checks them.
module tb_amba_apb4_mem_slave;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        sel_dut;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] prdata_m;
  logic        pready_m, pslverr_m;

  amba_apb4_mem_slave_if #(.ADDR_SIZE(32), .DATA_SIZE(32)) bus0 ();
  amba_apb4_mem_slave_if #(.ADDR_SIZE(32), .DATA_SIZE(32)) bus3 ();

  assign bus0.psel    = psel & ~sel_dut;
  assign bus0.penable = penable;
  assign bus0.pwrite  = pwrite;
  assign bus0.paddr   = paddr;
  assign bus0.pwdata  = pwdata;
  assign bus0.pstrb   = pstrb;
  assign bus0.pprot   = pprot;
  assign bus3.psel    = psel & sel_dut;
  assign bus3.penable = penable;
  assign bus3.pwrite  = pwrite;
  assign bus3.paddr   = paddr;
  assign bus3.pwdata  = pwdata;
  assign bus3.pstrb   = pstrb;
  assign bus3.pprot   = pprot;

  assign prdata_m  = sel_dut ? bus3.prdata  : bus0.prdata;
  assign pready_m  = sel_dut ? bus3.pready  : bus0.pready;
  assign pslverr_m = sel_dut ? bus3.pslverr : bus0.pslverr;

  amba_apb4_mem_slave #(
    .ADDR_SIZE(32), .DATA_SIZE(32), .MEM_DEPTH(256), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)
  ) u_dut0 (
    .pclk(clk), .preset(rst), .apb(bus0)
  );

  amba_apb4_mem_slave #(
    .ADDR_SIZE(32), .DATA_SIZE(32), .MEM_DEPTH(256), .BASE_ADDR(32'h0), .WAIT_CYCLES(3)
  ) u_dut3 (
    .pclk(clk), .preset(rst), .apb(bus3)
  );

  typedef struct packed {
    logic        is_read;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  lat;
    logic [15:0] id;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   acc_cnt  = 0;
  int   xid      = 0;
`ifdef APB_SLV_LFSR_WAIT_EN
  logic [15:0] lfsr_m [2];
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Latency = cycles with psel&penable up to and including the pready cycle (SETUP + ACCESS states).
  always @(negedge clk) begin
    if (psel && penable) begin
      acc_cnt++;
      if (pready_m) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pready", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check($sformatf("x%0d_pslverr", mon_e.id), {31'd0, pslverr_m}, {31'd0, mon_e.err});
          check($sformatf("x%0d_cycles", mon_e.id), acc_cnt, {24'd0, mon_e.lat});
          if (mon_e.is_read) begin
            check($sformatf("x%0d_prdata", mon_e.id), prdata_m, mon_e.rdata);
          end
          $display("xfer %0d dut%0d %s addr=0x%08h prdata=0x%08h pslverr=%0d cycles=%0d",
                   mon_e.id, sel_dut ? 3 : 0, mon_e.is_read ? "RD" : "WR",
                   mon_e.addr, prdata_m, pslverr_m, acc_cnt);
        end
        acc_cnt = 0;
      end
    end else begin
      acc_cnt = 0;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the completing edge with psel low.
  task automatic xfer(input logic d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] st, input logic [31:0] rd_exp, input logic err_exp);
    exp_t e;
    int   w;
    int   n;
    w = d ? 3 : 0;
`ifdef APB_SLV_LFSR_WAIT_EN
    w += int'(lfsr_m[d][2:0]);
    lfsr_m[d] = {lfsr_m[d][14:0], lfsr_m[d][15] ^ lfsr_m[d][13] ^ lfsr_m[d][12] ^ lfsr_m[d][10]};
`endif
    xid++;
    e.is_read = !wr;
    e.addr    = a;
    e.rdata   = rd_exp;
    e.err     = err_exp;
    e.lat     = 8'(2 + w);
    e.id      = 16'(xid);
    exp_q.push_back(e);
    sel_dut = d; psel = 1'b1; penable = 1'b0; pwrite = wr;
    paddr = a; pwdata = wd; pstrb = st;
    @(posedge clk); #1;
    // Bus changes during the access phase must be ignored by the slave.
    penable = 1'b1; paddr = a ^ 32'h4; pwdata = ~wd; pstrb = ~st;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (pready_m) break;
      n++;
      if (n > 40) begin
        check($sformatf("x%0d_timeout", xid), 32'd1, 32'd0);
        psel = 1'b0; penable = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; pstrb = 0;
    pprot = 3'b010; sel_dut = 0;
`ifdef APB_SLV_LFSR_WAIT_EN
    lfsr_m[0] = 16'hACE1; lfsr_m[1] = 16'hACE1;
`endif
    rst = 1'b1;
    repeat (50) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_prdata0",  bus0.prdata, 32'h0);
    check("rst_pready0",  {31'd0, bus0.pready}, 32'h0);
    check("rst_pslverr0", {31'd0, bus0.pslverr}, 32'h0);
    check("rst_prdata3",  bus3.prdata, 32'h0);
    idle(1);

    // dut0, no wait states
    xfer(0, 0, 32'h000, 32'h0,        4'h0, 32'h0,        0); idle(1);
    xfer(0, 1, 32'h040, 32'h12345678, 4'hF, 32'h0,        0); idle(1);
    xfer(0, 0, 32'h040, 32'h0,        4'h0, 32'h12345678, 0); idle(1);
    xfer(0, 1, 32'h018, 32'h22446688, 4'hF, 32'h0,        0); idle(1);
    xfer(0, 1, 32'h018, 32'hAABBCCDD, 4'h5, 32'h0,        0); idle(1);
    xfer(0, 0, 32'h018, 32'h0,        4'h0, 32'h22BB66DD, 0); idle(1);
    xfer(0, 1, 32'h000, 32'h0BADF00D, 4'hF, 32'h0,        0); idle(1);
    xfer(0, 1, 32'h400, 32'hDEADBEEF, 4'hF, 32'h0,        1); idle(1);
    xfer(0, 0, 32'h000, 32'h0,        4'h0, 32'h0BADF00D, 0); idle(1);
    xfer(0, 0, 32'h400, 32'h0,        4'h0, 32'h0,        1); idle(1);
    xfer(0, 1, 32'h3FC, 32'hCAFEBABE, 4'hF, 32'h0,        0); idle(1);
    xfer(0, 0, 32'h3FF, 32'h0,        4'h0, 32'hCAFEBABE, 0); idle(1);
    xfer(0, 1, 32'h020, 32'h11111111, 4'hF, 32'h0,        0); idle(1);
    xfer(0, 1, 32'h020, 32'hFFFFFFFF, 4'h0, 32'h0,        0); idle(1);
    xfer(0, 0, 32'h020, 32'h0,        4'h0, 32'h11111111, 0); idle(1);
    // back-to-back: unaligned write aliases word 0, read set up right after pready
    xfer(0, 1, 32'h003, 32'h00000008, 4'hF, 32'h0,        0);
    xfer(0, 0, 32'h000, 32'h0,        4'h0, 32'h00000008, 0);
    xfer(0, 0, 32'h018, 32'h0,        4'h0, 32'h22BB66DD, 0); idle(1);

    // psel with penable in IDLE is ignored
    sel_dut = 0; psel = 1; penable = 1; pwrite = 0; paddr = 32'h40;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("proterr_pready_%0d", i), {31'd0, bus0.pready}, 32'h0);
    end
    @(posedge clk); #1 psel = 0; penable = 0;
    idle(1);
    xfer(0, 0, 32'h040, 32'h0, 4'h0, 32'h12345678, 0); idle(1);

    // dut3, three wait states
    xfer(1, 1, 32'h040, 32'h55AA55AA, 4'hF, 32'h0,        0); idle(1);
    xfer(1, 0, 32'h040, 32'h0,        4'h0, 32'h55AA55AA, 0); idle(1);
    // abort a write after one ACCESS cycle
    sel_dut = 1; psel = 1; penable = 0; pwrite = 1; paddr = 32'h40; pwdata = 32'h0; pstrb = 4'hF;
    @(posedge clk); #1 penable = 1;
    @(posedge clk); #1;
    @(posedge clk); #1 psel = 0; penable = 0;
    idle(1);
    xfer(1, 0, 32'h040, 32'h0, 4'h0, 32'h55AA55AA, 0); idle(1);

    // reset in the middle of an ACCESS phase
    sel_dut = 1; psel = 1; penable = 0; pwrite = 1; paddr = 32'h44; pwdata = 32'h77; pstrb = 4'hF;
    @(posedge clk); #1 penable = 1;
    @(posedge clk); #1;
    rst = 1; psel = 0; penable = 0;
    #1;
    check("midrst_prdata3",  bus3.prdata, 32'h0);
    check("midrst_pready3",  {31'd0, bus3.pready}, 32'h0);
    check("midrst_pslverr3", {31'd0, bus3.pslverr}, 32'h0);
    check("midrst_prdata0",  bus0.prdata, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
`ifdef APB_SLV_LFSR_WAIT_EN
    lfsr_m[0] = 16'hACE1; lfsr_m[1] = 16'hACE1;
`endif
    idle(1);
    xfer(1, 0, 32'h044, 32'h0,        4'h0, 32'h0,        0); idle(1);
    xfer(1, 0, 32'h040, 32'h0,        4'h0, 32'h0,        0); idle(1);
    xfer(1, 1, 32'h044, 32'h00000099, 4'hF, 32'h0,        0); idle(1);
    xfer(1, 0, 32'h044, 32'h0,        4'h0, 32'h00000099, 0); idle(2);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
